i2s_tx_mc: RTL and testbench
============================

# i2s_tx_mc

Parametrised multi-channel I2S transmitter with integrated sample FIFO. It runs entirely in the system clock domain and generates the serial bit clock (sclk) and frame clock (lrclk) internally by division. It replaces the externally-clocked stereo serializer in the audio output path between the synthesizer mixer (producer) and the codec DAC pins.

## Interface
- DW, 24: sample width in bits.
- SW, 32: slot width in sclk periods. Must satisfy SW > DW.
- CH, 2: channels per frame. Must be even, 2..8.
- DEPTH, 16: FIFO depth in samples. Must be a power of 2 and at least CH.
- DIV, 4: Clk cycles per sclk half-period. Must be at least 1.

- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- write  in  1  sample valid.
- writedata  in  DW  two's-complement sample; channel order 0..CH-1, repeating.
- ready  out  1  FIFO can accept a sample.
- sclk  out  1  bit clock.
- lrclk  out  1  frame clock.
- streamout  out  1  serial data, MSB first.
- underrun  out  1  sticky flag: a frame was muted.
- clear_underrun  in  1  clears underrun.

## Operation
- Reset: sclk=0, lrclk=0, streamout=0, underrun=0, ready=1, FIFO empty, state IDLE, all counters 0.
- Push: a sample is accepted when write && ready. ready = (count < DEPTH), taken from the registered count. A write while full is dropped, including in a cycle where a pop occurs.
- States:
  - IDLE: outputs held at 0. Moves to RUN when enable=1.
  - RUN: serializes frames.
  - STOP: entered when enable=0 in RUN. Finishes the current frame, then returns to IDLE with the counters zeroed.
- Divider: sclk toggles every DIV Clk cycles while in RUN or STOP.
- Event timing:
  - A "fall" is the Clk cycle in which sclk goes 1->0.
  - The first fall comes 2*DIV cycles after entering RUN.
  - bit (0..SW-1) and slot (0..CH-1) advance on each fall and wrap.
- lrclk: updated on the fall that starts bit 0 of a slot. lrclk = (slot >= CH/2). For CH=2 this is standard I2S (left low, right high).
- Data, with a one-bit I2S delay:
  - At bit p with 1 <= p <= DW, streamout = sample[DW-p].
  - At all other bits streamout = 0.
  - Data changes only on falls.
- Frame decision at slot 0, bit 0:
  - If count >= CH, the frame is valid. One sample is popped at bit 0 of each slot into a DW-bit shift register.
  - Otherwise the frame is muted: all-zero data, no pops, underrun is set.
  - Muting a whole frame keeps channel alignment.
- clear_underrun: clears underrun. If a new underrun occurs in the same cycle, the set wins.
- Reset mid-frame: immediate return to reset values. FIFO contents are discarded.

## Timing
- Frame length is CH*SW sclk periods, which is 2*DIV*CH*SW Clk cycles.
- Write-to-ready latency: 1 cycle, because ready comes from the registered count.
- A pop updates count in the same cycle as the fall. A simultaneous push and pop leaves count unchanged.
- The output registers streamout, lrclk and sclk are all updated in the same Clk cycle, so there is no relative skew.
- The MSB of slot k appears 1 sclk period after the lrclk/slot boundary, and is stable across the following sclk rising edge.
- An enable toggle within a frame has no effect until the frame ends.

## Configuration
- I2S_TX_UNDERRUN_CNT_EN: adds output underrun_count (16 bits).
  - Increments once per muted frame and saturates at 16'hFFFF.
  - Cleared by Reset or clear_underrun.
- Without the macro, the port and its counter are absent. Only the sticky underrun flag exists.

## Structure
- Package i2s_pkg:
  - state enum {IDLE, RUN, STOP};
  - localparam-derived widths: clog2 of DEPTH, SW, CH, DIV;
  - the underrun counter width constant.
- Sub-module i2s_tx_fifo: synchronous FIFO with parameters DW and DEPTH and ports push/pop/din/dout/count. Read is first-word-fall-through, so the popped data is valid in the pop cycle.
- Divider, bit/slot counters, sequencer and serializer live in i2s_tx_mc.

## Test plan
- Reset mid-frame (DIV=1, SW=32, DW=24, CH=2; Reset asserted at bit 12 of slot 1) -> the next cycle shows sclk=lrclk=streamout=0 and ready=1; the FIFO reports empty.
- Stereo basic (same parameters; write 24'hA5F00F then 24'h123456; enable=1) -> slot 0 has lrclk=0 with bits 1..24 = A5F00F MSB-first, and bits 0 and 25..31 = 0. Slot 1 has lrclk=1 with 123456. The frame is 128 Clk cycles.
- Underrun (FIFO holds 1 sample, CH=2) -> the whole frame is zero, no pop occurs, underrun=1, and the held sample stays queued. A later write completes the pair and the next frame is valid.
- Full FIFO (DEPTH=4, enable=0, write 6 samples) -> samples 1-4 are accepted and ready=0 after the 4th. Samples 5-6 are dropped, and the output order is 1,2,3,4.
- TDM (CH=4, DIV=2) -> lrclk is low for slots 0-1 and high for slots 2-3. The 4 samples appear in order, and the frame is 512 Clk cycles.
- Stop and counter (enable drops at slot 0 bit 5) -> the frame completes, then IDLE with outputs 0. With I2S_TX_UNDERRUN_CNT_EN, 3 muted frames give underrun_count=3, and clear_underrun resets it to 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and width helpers for the multi-channel I2S transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int I2S_DW    = 24;
  localparam int I2S_SW    = 32;
  localparam int I2S_CH    = 2;
  localparam int I2S_DEPTH = 16;
  localparam int I2S_DIV   = 4;

  localparam int UNDERRUN_CNT_W = 16;
  typedef logic [UNDERRUN_CNT_W-1:0] underrunCnt_t;

  // Counter width for a modulus n; never narrower than one bit so DIV=1 still has a register.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous sample FIFO with first-word-fall-through read: dout is the head sample,
// valid in the same cycle pop is asserted.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DW    = I2S_DW,
  parameter int DEPTH = I2S_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = cntWidth(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  // Full/empty guards use the registered count, so a push while full is lost even if a pop frees a slot.
  assign doPush = push && (count < FULL);
  assign doPop  = pop && (count != '0);
  assign dout   = mem[rdPtr];

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_mc.sv
// Multi-channel I2S transmitter: internal sclk/lrclk division, sample FIFO, framed serializer.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit muted-frame counter output.
module i2s_tx_mc
  import i2s_pkg::*;
#(
  parameter int DW    = I2S_DW,
  parameter int SW    = I2S_SW,
  parameter int CH    = I2S_CH,
  parameter int DEPTH = I2S_DEPTH,
  parameter int DIV   = I2S_DIV
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          enable,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  output logic          ready,
  output logic          sclk,
  output logic          lrclk,
  output logic          streamout,
  output logic          underrun,
  input  logic          clear_underrun,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output underrunCnt_t  underrun_count,
`endif
  output state_t        dbgState
);

  localparam int BW  = cntWidth(SW);
  localparam int SLW = cntWidth(CH);
  localparam int DVW = cntWidth(DIV);
  localparam int CW  = $clog2(DEPTH) + 1;

  localparam logic [BW-1:0]  BIT_LAST  = BW'(SW - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DW);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(CH - 1);
  localparam logic [SLW-1:0] SLOT_HALF = SLW'(CH / 2);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_FRAME = CW'(CH);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);

  state_t         state;
  state_t         stateNext;
  logic           running;
  logic [DVW-1:0] divCnt;
  logic [BW-1:0]  bitCnt;
  logic [SLW-1:0] slotCnt;
  logic [DW-1:0]  shiftReg;
  logic           frameValid;
  logic [DW-1:0]  fifoDout;
  logic [CW-1:0]  fifoCount;

  logic tick;
  logic fall;
  logic atBit0;
  logic frameStart;
  logic beginFrame;
  logic goIdle;
  logic haveFrame;
  logic muteStart;
  logic pop;

  // Sample handshake: a sample transfers on any Clk edge where write && ready; ready is
  // derived from the registered FIFO count, and writes presented while ready=0 are discarded.
  assign ready = (fifoCount < CNT_FULL);

  i2s_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (write),
    .pop   (pop),
    .din   (writedata),
    .dout  (fifoDout),
    .count (fifoCount)
  );

  // bitCnt/slotCnt name the bit a fall is about to present, so counters at 0/0 mark a frame boundary.
  assign tick       = running && (divCnt == DIV_LAST);
  assign fall       = tick && sclk;
  assign atBit0     = fall && (bitCnt == '0);
  assign frameStart = atBit0 && (slotCnt == '0);
  assign beginFrame = frameStart && enable;
  assign goIdle     = frameStart && !enable;
  assign haveFrame  = (fifoCount >= CNT_FRAME);
  assign muteStart  = beginFrame && !haveFrame;
  assign pop        = atBit0 && ((slotCnt == '0) ? (enable && haveFrame) : frameValid);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Enable is only acted on at a frame boundary once a frame is under way.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (enable) stateNext = RUN;
      RUN: begin
        if (goIdle)       stateNext = IDLE;
        else if (!enable) stateNext = STOP;
      end
      STOP: if (frameStart) stateNext = enable ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    running  = (state != IDLE);
    dbgState = state;
  end

  always_ff @(posedge Clk) begin
    if (Reset || !running) begin
      divCnt     <= '0;
      sclk       <= 1'b0;
      lrclk      <= 1'b0;
      streamout  <= 1'b0;
      bitCnt     <= '0;
      slotCnt    <= '0;
      shiftReg   <= '0;
      frameValid <= 1'b0;
    end else begin
      divCnt <= tick ? '0 : divCnt + 1'b1;
      if (goIdle) begin
        sclk       <= 1'b0;
        lrclk      <= 1'b0;
        streamout  <= 1'b0;
        bitCnt     <= '0;
        slotCnt    <= '0;
        shiftReg   <= '0;
        frameValid <= 1'b0;
      end else if (tick) begin
        sclk <= !sclk;
        if (fall) begin
          bitCnt <= (bitCnt == BIT_LAST) ? '0 : bitCnt + 1'b1;
          if (bitCnt == BIT_LAST)
            slotCnt <= (slotCnt == SLOT_LAST) ? '0 : slotCnt + 1'b1;
          // Bit 0 carries the I2S one-bit delay: load the slot sample, drive a zero.
          if (bitCnt == '0) begin
            lrclk     <= (slotCnt >= SLOT_HALF);
            shiftReg  <= pop ? fifoDout : '0;
            streamout <= 1'b0;
            if (slotCnt == '0) frameValid <= haveFrame;
          end else if (bitCnt <= DATA_LAST) begin
            streamout <= shiftReg[DW-1];
            shiftReg  <= {shiftReg[DW-2:0], 1'b0};
          end else begin
            streamout <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)               underrun <= 1'b0;
    else if (muteStart)      underrun <= 1'b1;
    else if (clear_underrun) underrun <= 1'b0;
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      underrun_count <= '0;
    else if (clear_underrun)
      underrun_count <= muteStart ? UNDERRUN_CNT_W'(1) : '0;
    else if (muteStart && (underrun_count != '1))
      underrun_count <= underrun_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2s_tx_mc.sv
// Directed bench for i2s_tx_mc: a stereo DIV=1 instance and a 4-channel TDM DIV=2 instance.
module tb_i2s_tx_mc;
  import i2s_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  logic Reset;

  logic        a_enable, a_write, a_ready, a_sclk, a_lrclk, a_stream, a_underrun, a_clr;
  logic [23:0] a_wdata;
  state_t      a_state;
  logic        b_enable, b_write, b_ready, b_sclk, b_lrclk, b_stream, b_underrun, b_clr;
  logic [23:0] b_wdata;
  state_t      b_state;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] a_ucnt, b_ucnt;
`endif

  int compared = 0;
  int mismatched = 0;

  logic cap_bit [0:255];
  logic cap_lr  [0:255];
  int   cap_cyc [0:255];

  i2s_tx_mc #(.DW(24), .SW(32), .CH(2), .DEPTH(4), .DIV(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .enable(a_enable), .write(a_write), .writedata(a_wdata),
    .ready(a_ready), .sclk(a_sclk), .lrclk(a_lrclk), .streamout(a_stream),
    .underrun(a_underrun), .clear_underrun(a_clr),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun_count(a_ucnt),
`endif
    .dbgState(a_state)
  );

  i2s_tx_mc #(.DW(24), .SW(32), .CH(4), .DEPTH(8), .DIV(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .enable(b_enable), .write(b_write), .writedata(b_wdata),
    .ready(b_ready), .sclk(b_sclk), .lrclk(b_lrclk), .streamout(b_stream),
    .underrun(b_underrun), .clear_underrun(b_clr),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun_count(b_ucnt),
`endif
    .dbgState(b_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] slot_word(input int base);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[31-b] = cap_bit[base+b];
    return w;
  endfunction

  function automatic logic [31:0] lr_word(input int base);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[31-b] = cap_lr[base+b];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    a_enable = 1'b0; b_enable = 1'b0;
    a_write = 1'b0;  b_write = 1'b0;
    a_clr = 1'b0;    b_clr = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic put(input int which, input logic [23:0] d);
    @(negedge Clk);
    if (which == 0) begin a_write = 1'b1; a_wdata = d; end
    else            begin b_write = 1'b1; b_wdata = d; end
    @(negedge Clk);
    a_write = 1'b0;
    b_write = 1'b0;
  endtask

  // Record streamout/lrclk at each sclk rising edge; index 0 is the rise before the first frame.
  // hook_kind 1 writes hook_data into instance A at rise hook_at, 2 drops A's enable there.
  task automatic collect(input int which, input int n, input int hook_at, input int hook_kind,
                         input logic [23:0] hook_data);
    int r = 0;
    int budget = n * 8 + 64;
    logic prev, cur;
    prev = (which == 0) ? a_sclk : b_sclk;
    while (r < n && budget > 0) begin
      @(negedge Clk);
      budget--;
      a_write = 1'b0;
      cur = (which == 0) ? a_sclk : b_sclk;
      if (cur && !prev) begin
        cap_bit[r] = (which == 0) ? a_stream : b_stream;
        cap_lr[r]  = (which == 0) ? a_lrclk : b_lrclk;
        cap_cyc[r] = cyc;
        if (r == hook_at && hook_kind == 1) begin a_write = 1'b1; a_wdata = hook_data; end
        if (r == hook_at && hook_kind == 2) a_enable = 1'b0;
        r++;
      end
      prev = cur;
    end
    if (a_write) begin
      @(negedge Clk);
      a_write = 1'b0;
    end
    compared++;
    if (r != n) begin
      mismatched++;
      $display("FAIL collect_timeout: got %0d rises want %0d", r, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (a_sclk !== 1'b0)     begin mismatched++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
    compared++; if (a_lrclk !== 1'b0)    begin mismatched++; $display("FAIL reset_lrclk: got %b want 0", a_lrclk); end
    compared++; if (a_stream !== 1'b0)   begin mismatched++; $display("FAIL reset_stream: got %b want 0", a_stream); end
    compared++; if (a_underrun !== 1'b0) begin mismatched++; $display("FAIL reset_underrun: got %b want 0", a_underrun); end
    compared++; if (a_ready !== 1'b1)    begin mismatched++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    compared++; if (a_state !== IDLE)    begin mismatched++; $display("FAIL reset_state: got %0d want IDLE", a_state); end
    compared++; if (b_ready !== 1'b1)    begin mismatched++; $display("FAIL reset_ready_b: got %b want 1", b_ready); end
  endtask

  task automatic test_stereo();
    logic [23:0] s [2];
    logic [31:0] got, want;
    s[0] = 24'hA5F00F; s[1] = 24'h123456;
    do_reset();
    put(0, s[0]); put(0, s[1]);
    compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL stereo_ready: got %b want 1", a_ready); end
    a_enable = 1'b1;
    collect(0, 66, -1, 0, 24'h0);
    for (int k = 0; k < 2; k++) begin
      got = slot_word(1 + 32*k); want = {1'b0, s[k], 7'b0};
      compared++; if (got !== want) begin mismatched++; $display("FAIL stereo_data%0d: got %h want %h", k, got, want); end
      got = lr_word(1 + 32*k); want = (k == 0) ? 32'h0 : 32'hFFFFFFFF;
      compared++; if (got !== want) begin mismatched++; $display("FAIL stereo_lr%0d: got %h want %h", k, got, want); end
    end
    compared++;
    if (cap_cyc[64] - cap_cyc[0] != 128) begin
      mismatched++; $display("FAIL stereo_frame_len: got %0d want 128", cap_cyc[64] - cap_cyc[0]);
    end
    compared++; if (a_underrun !== 1'b1) begin mismatched++; $display("FAIL stereo_empty_underrun: got %b want 1", a_underrun); end
    a_enable = 1'b0;
    for (int i = 0; i < 300 && a_state !== IDLE; i++) @(negedge Clk);
    compared++; if (a_state !== IDLE) begin mismatched++; $display("FAIL stereo_idle: got %0d want IDLE", a_state); end
    a_clr = 1'b1;
    @(negedge Clk);
    a_clr = 1'b0;
    compared++; if (a_underrun !== 1'b0) begin mismatched++; $display("FAIL stereo_clear: got %b want 0", a_underrun); end
  endtask

  task automatic test_underrun();
    logic [31:0] got, want;
    do_reset();
    put(0, 24'h111111);
    a_enable = 1'b1;
    collect(0, 129, 40, 1, 24'h222222);
    for (int k = 0; k < 2; k++) begin
      got = slot_word(1 + 32*k);
      compared++; if (got !== 32'h0) begin mismatched++; $display("FAIL underrun_mute%0d: got %h want 0", k, got); end
    end
    got = slot_word(65); want = {1'b0, 24'h111111, 7'b0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL underrun_held: got %h want %h", got, want); end
    got = slot_word(97); want = {1'b0, 24'h222222, 7'b0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL underrun_pair: got %h want %h", got, want); end
    compared++; if (a_underrun !== 1'b1) begin mismatched++; $display("FAIL underrun_flag: got %b want 1", a_underrun); end
    a_enable = 1'b0;
    for (int i = 0; i < 300 && a_state !== IDLE; i++) @(negedge Clk);
    compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL underrun_drained: got %b want 1", a_ready); end
  endtask

  task automatic test_full();
    logic [31:0] got, want;
    logic [23:0] v;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = 24'h100001 + 24'(i);
      put(0, v);
      compared++;
      if (a_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
        mismatched++; $display("FAIL full_ready%0d: got %b want %b", i, a_ready, (i < 3));
      end
    end
    a_enable = 1'b1;
    collect(0, 129, -1, 0, 24'h0);
    a_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = 24'h100001 + 24'(k);
      got = slot_word(1 + 32*k); want = {1'b0, v, 7'b0};
      compared++; if (got !== want) begin mismatched++; $display("FAIL full_order%0d: got %h want %h", k, got, want); end
    end
    for (int i = 0; i < 300 && a_state !== IDLE; i++) @(negedge Clk);
    compared++; if (a_underrun !== 1'b0) begin mismatched++; $display("FAIL full_no_underrun: got %b want 0", a_underrun); end
    compared++; if (a_ready !== 1'b1)    begin mismatched++; $display("FAIL full_drained: got %b want 1", a_ready); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] s1;
    s1 = 24'h13579B;
    do_reset();
    put(0, 24'hABCDEF); put(0, s1); put(0, 24'h2468AC);
    a_enable = 1'b1;
    collect(0, 46, -1, 0, 24'h0);
    compared++; if (cap_bit[45] !== s1[24-12]) begin mismatched++; $display("FAIL mid_bit12: got %b want %b", cap_bit[45], s1[24-12]); end
    compared++; if (a_lrclk !== 1'b1) begin mismatched++; $display("FAIL mid_lrclk_pre: got %b want 1", a_lrclk); end
    Reset = 1'b1;
    a_enable = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    compared++; if (a_sclk !== 1'b0)   begin mismatched++; $display("FAIL mid_sclk: got %b want 0", a_sclk); end
    compared++; if (a_lrclk !== 1'b0)  begin mismatched++; $display("FAIL mid_lrclk: got %b want 0", a_lrclk); end
    compared++; if (a_stream !== 1'b0) begin mismatched++; $display("FAIL mid_stream: got %b want 0", a_stream); end
    compared++; if (a_ready !== 1'b1)  begin mismatched++; $display("FAIL mid_ready: got %b want 1", a_ready); end
    compared++; if (a_state !== IDLE)  begin mismatched++; $display("FAIL mid_state: got %0d want IDLE", a_state); end
    for (int i = 0; i < 3; i++) put(0, 24'h0F0000 + 24'(i));
    compared++; if (a_ready !== 1'b1) begin mismatched++; $display("FAIL mid_empty3: got %b want 1", a_ready); end
    put(0, 24'h0F0003);
    compared++; if (a_ready !== 1'b0) begin mismatched++; $display("FAIL mid_empty4: got %b want 0", a_ready); end
  endtask

  task automatic test_tdm();
    logic [23:0] s [4];
    logic [31:0] got, want;
    s[0] = 24'h0F0F0F; s[1] = 24'hF0F0F0; s[2] = 24'h800001; s[3] = 24'h7FFFFE;
    do_reset();
    for (int k = 0; k < 4; k++) put(1, s[k]);
    b_enable = 1'b1;
    collect(1, 129, -1, 0, 24'h0);
    b_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = slot_word(1 + 32*k); want = {1'b0, s[k], 7'b0};
      compared++; if (got !== want) begin mismatched++; $display("FAIL tdm_data%0d: got %h want %h", k, got, want); end
      got = lr_word(1 + 32*k); want = (k < 2) ? 32'h0 : 32'hFFFFFFFF;
      compared++; if (got !== want) begin mismatched++; $display("FAIL tdm_lr%0d: got %h want %h", k, got, want); end
    end
    compared++;
    if (cap_cyc[128] - cap_cyc[0] != 512) begin
      mismatched++; $display("FAIL tdm_frame_len: got %0d want 512", cap_cyc[128] - cap_cyc[0]);
    end
    for (int i = 0; i < 800 && b_state !== IDLE; i++) @(negedge Clk);
    compared++; if (b_state !== IDLE) begin mismatched++; $display("FAIL tdm_idle: got %0d want IDLE", b_state); end
  endtask

  task automatic test_stop();
    logic [31:0] got, want;
    do_reset();
    put(0, 24'h3C3C3C); put(0, 24'hC3C3C3); put(0, 24'h5A5A5A); put(0, 24'hA5A5A5);
    a_enable = 1'b1;
    collect(0, 65, 6, 2, 24'h0);
    compared++; if (a_state !== STOP) begin mismatched++; $display("FAIL stop_state: got %0d want STOP", a_state); end
    @(negedge Clk);
    compared++; if (a_state !== IDLE)  begin mismatched++; $display("FAIL stop_idle: got %0d want IDLE", a_state); end
    compared++; if (a_lrclk !== 1'b0)  begin mismatched++; $display("FAIL stop_lrclk: got %b want 0", a_lrclk); end
    compared++; if (a_sclk !== 1'b0)   begin mismatched++; $display("FAIL stop_sclk: got %b want 0", a_sclk); end
    compared++; if (a_stream !== 1'b0) begin mismatched++; $display("FAIL stop_stream: got %b want 0", a_stream); end
    got = slot_word(1); want = {1'b0, 24'h3C3C3C, 7'b0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL stop_data0: got %h want %h", got, want); end
    got = slot_word(33); want = {1'b0, 24'hC3C3C3, 7'b0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL stop_data1: got %h want %h", got, want); end
    a_enable = 1'b1;
    collect(0, 65, -1, 0, 24'h0);
    a_enable = 1'b0;
    got = slot_word(1); want = {1'b0, 24'h5A5A5A, 7'b0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL restart_data0: got %h want %h", got, want); end
    got = slot_word(33); want = {1'b0, 24'hA5A5A5, 7'b0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL restart_data1: got %h want %h", got, want); end
    @(negedge Clk);
    compared++; if (a_state !== IDLE) begin mismatched++; $display("FAIL restart_idle: got %0d want IDLE", a_state); end
    compared++; if (a_underrun !== 1'b0) begin mismatched++; $display("FAIL stop_underrun: got %b want 0", a_underrun); end
  endtask

  task automatic test_underrun_count();
    logic [31:0] got;
    do_reset();
    a_enable = 1'b1;
    collect(0, 193, -1, 0, 24'h0);
    a_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      got = slot_word(1 + 32*k);
      compared++; if (got !== 32'h0) begin mismatched++; $display("FAIL cnt_mute%0d: got %h want 0", k, got); end
    end
    @(negedge Clk);
    compared++; if (a_state !== IDLE)    begin mismatched++; $display("FAIL cnt_idle: got %0d want IDLE", a_state); end
    compared++; if (a_underrun !== 1'b1) begin mismatched++; $display("FAIL cnt_flag: got %b want 1", a_underrun); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    compared++; if (a_ucnt !== 16'd3) begin mismatched++; $display("FAIL cnt_value: got %0d want 3", a_ucnt); end
`endif
    a_clr = 1'b1;
    @(negedge Clk);
    a_clr = 1'b0;
    compared++; if (a_underrun !== 1'b0) begin mismatched++; $display("FAIL cnt_flag_clear: got %b want 0", a_underrun); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    compared++; if (a_ucnt !== 16'd0) begin mismatched++; $display("FAIL cnt_clear: got %0d want 0", a_ucnt); end
`endif
  endtask

  initial begin
    Reset = 1'b1;
    a_enable = 1'b0; a_write = 1'b0; a_wdata = '0; a_clr = 1'b0;
    b_enable = 1'b0; b_write = 1'b0; b_wdata = '0; b_clr = 1'b0;
    test_reset();
    test_stereo();
    test_underrun();
    test_full();
    test_reset_mid();
    test_tdm();
    test_stop();
    test_underrun_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
